and_gate_bank: RTL and testbench
================================

# and_gate_bank

Bitwise AND primitive bank bundling the 2-, 3- and 4-input AND functions (`and_gate`, `and3_gate`, `and4_gate`) behind one clocked wrapper. Each function is available as a combinational output and as a registered output. It sits at the bottom of the lab gate library and serves as the glue-logic source for the mux and decoder blocks.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of every data input and output. All operations are bitwise per lane.

Ports:
- `clk`  in  1: single clock. All registered outputs update on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: register load enable. When 0, the registered outputs hold their value.
- `i_1`  in  WIDTH: operand 1.
- `i_2`  in  WIDTH: operand 2.
- `i_3`  in  WIDTH: operand 3.
- `i_4`  in  WIDTH: operand 4.
- `o`  out  WIDTH: combinational `i_1 & i_2`.
- `o_3`  out  WIDTH: combinational `i_1 & i_2 & i_3`.
- `o_4`  out  WIDTH: combinational `i_1 & i_2 & i_3 & i_4`.
- `o_q`  out  WIDTH: registered copy of `o`.
- `o_3_q`  out  WIDTH: registered copy of `o_3`.
- `o_4_q`  out  WIDTH: registered copy of `o_4`.

## Operation
- Combinational path per bit lane k:
  - `o[k]` is 1 only when `i_1[k]` and `i_2[k]` are both 1.
  - `o_3[k]` additionally requires `i_3[k]`.
  - `o_4[k]` additionally requires `i_3[k]` and `i_4[k]`.
  - Otherwise the lane is 0.
- The combinational outputs do not depend on `clk`, `rst` or `en`.
- Register path, evaluated each rising `clk`, in priority order:
  - `rst`=1: `o_q`, `o_3_q` and `o_4_q` are all cleared to 0.
  - Else `en`=1: each register loads its combinational counterpart.
  - Else: all three registers hold.
- X/Z handling follows standard Verilog `&` semantics: a 0 on any operand forces that lane to 0, even when other operands are X.
- No state machine. The only state is the three output registers.

## Timing
- Combinational outputs: zero-cycle latency, settling within the same delta/timestep as the input change.
- Registered outputs: one-cycle latency. Inputs sampled at edge N appear on `*_q` after edge N.
- Reset value: all `*_q` outputs are 0. Combinational outputs are unaffected by reset.
- `rst` and `en` both high: reset wins.
- `rst` deasserted with `en` high: the first edge after deassertion loads the current inputs.
- Reset asserted mid-stream: the next edge clears the registers, and the in-flight sample is discarded.
- Inputs changing between edges: only the value present at the edge is captured. Glitches are not registered.

## Structure
- Leaf sub-module `and_gate`: 2-input, WIDTH-parameterised, purely combinational (`i_1`, `i_2`, `o`).
- `and3_gate` is built from two `and_gate` instances in a chain.
- `and4_gate` is built from three `and_gate` instances in a balanced tree: (1&2), (3&4), then the final AND.
- The top `and_gate_bank` instantiates one `and_gate`, one `and3_gate` and one `and4_gate`, plus the output register block.
- Shared package: only the default `WIDTH` constant. No typedefs are needed.

## Test plan
- 2-input truth table, WIDTH=1: (1,1), (0,0), (1,0), (0,1), (1,1) applied 10 ns apart gives `o` = 1, 0, 0, 0, 1.
- 3-input exhaustive, WIDTH=1: sweep `i_1 i_2 i_3` from 000 to 111 in 10 ns steps. `o_3` must be 1 only at 111.
- 4-input exhaustive, WIDTH=1: sweep all 16 combinations with `i_4` as the MSB. `o_4` must be 1 only when all four inputs are 1 (the final step).
- Register path: with `rst`=1 held for 2 edges, all `*_q` read 0. Then with `rst`=0, `en`=1 and all inputs 1, all `*_q` read 1 one edge later. Then dropping `en` to 0 and driving `i_1`=0, `*_q` stay 1 while `o`, `o_3` and `o_4` go to 0 immediately.
- Priority and mid-stream reset: set `rst`=1 and `en`=1 with all inputs 1 and the `*_q` outputs at 1. After the next edge, all `*_q` read 0.
- Vector lanes, WIDTH=4: with `i_1`=4'b1111, `i_2`=4'b1010, `i_3`=4'b1100 and `i_4`=4'b1000, the outputs are `o`=1010, `o_3`=1000 and `o_4`=1000.

Source files
------------

// File: rtl/and_gate_bank_pkg.sv
// Shared constants for the AND primitive bank.
// No latency: the package holds only compile-time constants.
// No flow control: nothing here carries data.
package and_gate_bank_pkg;

  // Lane count used when the instantiating block does not override WIDTH
  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/and3_gate.sv
// 3-input bitwise AND as a two-stage chain of 2-input leaves.
// Zero latency: purely combinational.
// No backpressure: the output follows the inputs continuously.
module and3_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] and_12;

  // First stage combines operands 1 and 2
  and_gate #(.WIDTH(WIDTH)) u_and_12 (
    .i_1 (i_1),
    .i_2 (i_2),
    .o   (and_12)
  );

  // Second stage folds in operand 3
  and_gate #(.WIDTH(WIDTH)) u_and_123 (
    .i_1 (and_12),
    .i_2 (i_3),
    .o   (o)
  );

endmodule

// File: rtl/and4_gate.sv
// 4-input bitwise AND as a balanced tree of 2-input leaves.
// Zero latency: purely combinational, two gate levels deep.
// No backpressure: the output follows the inputs continuously.
module and4_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  input  logic [WIDTH-1:0] i_4,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] and_12;
  logic [WIDTH-1:0] and_34;

  // Left branch of the tree
  and_gate #(.WIDTH(WIDTH)) u_and_12 (
    .i_1 (i_1),
    .i_2 (i_2),
    .o   (and_12)
  );

  // Right branch of the tree
  and_gate #(.WIDTH(WIDTH)) u_and_34 (
    .i_1 (i_3),
    .i_2 (i_4),
    .o   (and_34)
  );

  // Root joins the two branches
  and_gate #(.WIDTH(WIDTH)) u_and_root (
    .i_1 (and_12),
    .i_2 (and_34),
    .o   (o)
  );

endmodule

// File: rtl/and_gate.sv
// Leaf 2-input bitwise AND, one result per lane.
// Zero latency: purely combinational.
// No backpressure: the output follows the inputs continuously.
module and_gate #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  output logic [WIDTH-1:0] o
);

  // A 0 on either operand forces the lane low, even against X
  assign o = i_1 & i_2;

endmodule

// File: rtl/and_gate_bank.sv
// Bank of 2/3/4-input bitwise ANDs with combinational and registered copies.
// Combinational outputs: 0 cycles; *_q outputs: 1 cycle after the sampling edge.
// No backpressure: en=0 freezes the registers, rst clears them and overrides en.
module and_gate_bank
  import and_gate_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  input  logic [WIDTH-1:0] i_4,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_3,
  output logic [WIDTH-1:0] o_4,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_3_q,
  output logic [WIDTH-1:0] o_4_q
);

  and_gate #(.WIDTH(WIDTH)) u_and2 (
    .i_1 (i_1),
    .i_2 (i_2),
    .o   (o)
  );

  and3_gate #(.WIDTH(WIDTH)) u_and3 (
    .i_1 (i_1),
    .i_2 (i_2),
    .i_3 (i_3),
    .o   (o_3)
  );

  and4_gate #(.WIDTH(WIDTH)) u_and4 (
    .i_1 (i_1),
    .i_2 (i_2),
    .i_3 (i_3),
    .i_4 (i_4),
    .o   (o_4)
  );

  // Output registers: reset beats load, load beats hold
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q   <= '0;
      o_3_q <= '0;
      o_4_q <= '0;
    end else if (en) begin
      o_q   <= o;
      o_3_q <= o_3;
      o_4_q <= o_4;
    end
  end

endmodule

// File: tb/tb_and_gate_bank.sv
// Self-checking bench for and_gate_bank at WIDTH=1 and WIDTH=4.
// Expected values are queued as stimulus is driven and popped when sampled.
// Sampling happens 1 ns after a drive or after the rising edge.
module tb_and_gate_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;

  // WIDTH=1 instance signals
  logic s_i_1, s_i_2, s_i_3, s_i_4;
  logic s_o, s_o_3, s_o_4, s_o_q, s_o_3_q, s_o_4_q;

  // WIDTH=4 instance signals
  logic [3:0] v_i_1, v_i_2, v_i_3, v_i_4;
  logic [3:0] v_o, v_o_3, v_o_4, v_o_q, v_o_3_q, v_o_4_q;

  and_gate_bank u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i_1   (s_i_1),
    .i_2   (s_i_2),
    .i_3   (s_i_3),
    .i_4   (s_i_4),
    .o     (s_o),
    .o_3   (s_o_3),
    .o_4   (s_o_4),
    .o_q   (s_o_q),
    .o_3_q (s_o_3_q),
    .o_4_q (s_o_4_q)
  );

  and_gate_bank #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i_1   (v_i_1),
    .i_2   (v_i_2),
    .i_3   (v_i_3),
    .i_4   (v_i_4),
    .o     (v_o),
    .o_3   (v_o_3),
    .o_4   (v_o_4),
    .o_q   (v_o_q),
    .o_3_q (v_o_3_q),
    .o_4_q (v_o_4_q)
  );

  // Output selectors for scoreboard entries
  localparam int S_O = 0, S_O3 = 1, S_O4 = 2, S_OQ = 3, S_O3Q = 4, S_O4Q = 5;
  localparam int V_O = 6, V_O3 = 7, V_O4 = 8, V_OQ = 9, V_O3Q = 10, V_O4Q = 11;

  typedef struct {
    string      tag;
    int         sel;
    logic [3:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  function automatic logic [3:0] get_out(int sel);
    case (sel)
      S_O:     return {3'b000, s_o};
      S_O3:    return {3'b000, s_o_3};
      S_O4:    return {3'b000, s_o_4};
      S_OQ:    return {3'b000, s_o_q};
      S_O3Q:   return {3'b000, s_o_3_q};
      S_O4Q:   return {3'b000, s_o_4_q};
      V_O:     return v_o;
      V_O3:    return v_o_3;
      V_O4:    return v_o_4;
      V_OQ:    return v_o_q;
      V_O3Q:   return v_o_3_q;
      default: return v_o_4_q;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [3:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, get_out(e.sel), e.exp);
    end
  endtask

  task automatic push_q1(input string tag, input logic [3:0] exp);
    push({tag, ".o_q"},   S_OQ,  exp);
    push({tag, ".o_3_q"}, S_O3Q, exp);
    push({tag, ".o_4_q"}, S_O4Q, exp);
  endtask

  task automatic push_q4(input string tag, input logic [3:0] exp);
    push({tag, ".v_o_q"},   V_OQ,  exp);
    push({tag, ".v_o_3_q"}, V_O3Q, exp);
    push({tag, ".v_o_4_q"}, V_O4Q, exp);
  endtask

  task automatic set_all(input logic s, input logic [3:0] v);
    s_i_1 = s; s_i_2 = s; s_i_3 = s; s_i_4 = s;
    v_i_1 = v; v_i_2 = v; v_i_3 = v; v_i_4 = v;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] tt_a, tt_b;
    logic [4:0] tt_exp;
    logic [3:0] idx;
    logic [3:0] ra, rb, rc, rd, e2, e3, e4;

    rst = 1'b1;
    en  = 1'b0;
    set_all(1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    push_q1("reset_state", 4'h0);
    push_q4("reset_state", 4'h0);
    drain();

    // 2-input truth table: (1,1),(0,0),(1,0),(0,1),(1,1) -> 1,0,0,0,1
    tt_exp = 5'b10001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      case (k)
        0, 4:    begin tt_a = 2'd1; tt_b = 2'd1; end
        1:       begin tt_a = 2'd0; tt_b = 2'd0; end
        2:       begin tt_a = 2'd1; tt_b = 2'd0; end
        default: begin tt_a = 2'd0; tt_b = 2'd1; end
      endcase
      s_i_1 = tt_a[0];
      s_i_2 = tt_b[0];
      push($sformatf("and2_tt%0d", k), S_O, {3'b000, tt_exp[k]});
      #1;
      drain();
    end

    // 3-input exhaustive: i_1 i_2 i_3 = idx[2:0], only 111 yields 1
    s_i_4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idx = 4'(k);
      s_i_1 = idx[2];
      s_i_2 = idx[1];
      s_i_3 = idx[0];
      push($sformatf("and3_sweep%0d", k), S_O3, (k == 7) ? 4'h1 : 4'h0);
      push($sformatf("and3_sweep%0d.o", k), S_O, (k >= 6) ? 4'h1 : 4'h0);
      #1;
      drain();
    end

    // 4-input exhaustive with i_4 as MSB, only 1111 yields 1
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = 4'(k);
      s_i_4 = idx[3];
      s_i_3 = idx[2];
      s_i_2 = idx[1];
      s_i_1 = idx[0];
      push($sformatf("and4_sweep%0d", k), S_O4, (k == 15) ? 4'h1 : 4'h0);
      #1;
      drain();
    end

    // A 0 operand dominates X operands
    @(negedge clk);
    s_i_1 = 1'b0; s_i_2 = 1'bx; s_i_3 = 1'bx; s_i_4 = 1'bx;
    push("x_dom.o", S_O, 4'h0);
    push("x_dom.o_3", S_O3, 4'h0);
    push("x_dom.o_4", S_O4, 4'h0);
    #1;
    drain();

    // Reset held throughout: registers still 0
    push_q1("reset_hold", 4'h0);
    drain();

    // Release reset with en=1 and all ones: loads one edge later
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    set_all(1'b1, 4'hF);
    @(posedge clk);
    #1;
    push_q1("load_ones", 4'h1);
    push_q4("load_ones", 4'hF);
    drain();

    // Drop en and clear i_1: comb falls immediately, registers hold
    @(negedge clk);
    en = 1'b0;
    s_i_1 = 1'b0;
    v_i_1 = 4'h0;
    #1;
    push("hold.o", S_O, 4'h0);
    push("hold.o_3", S_O3, 4'h0);
    push("hold.o_4", S_O4, 4'h0);
    push("hold.v_o_4", V_O4, 4'h0);
    push_q1("hold_pre", 4'h1);
    drain();
    @(posedge clk);
    #1;
    push_q1("hold_edge", 4'h1);
    push_q4("hold_edge", 4'hF);
    drain();

    // rst and en together: reset wins; comb path unaffected by reset
    @(negedge clk);
    set_all(1'b1, 4'hF);
    en  = 1'b1;
    rst = 1'b1;
    #1;
    push("prio.o_4", S_O4, 4'h1);
    push("prio.v_o", V_O, 4'hF);
    push_q1("prio_pre", 4'h1);
    drain();
    @(posedge clk);
    #1;
    push_q1("prio_rst", 4'h0);
    push_q4("prio_rst", 4'h0);
    drain();

    // First edge after deassertion with en high loads current inputs
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_q1("deassert_load", 4'h1);
    push_q4("deassert_load", 4'hF);
    drain();

    // A pulse between edges is not captured; only the edge value counts
    @(negedge clk);
    s_i_1 = 1'b0; v_i_1 = 4'h0;
    #2;
    s_i_1 = 1'b1; v_i_1 = 4'hF;
    #1;
    s_i_1 = 1'b0; v_i_1 = 4'h0;
    @(posedge clk);
    #1;
    push_q1("glitch", 4'h0);
    push_q4("glitch", 4'h0);
    drain();

    // Vector lanes: 1111,1010,1100,1000 -> 1010,1000,1000
    @(negedge clk);
    v_i_1 = 4'b1111; v_i_2 = 4'b1010; v_i_3 = 4'b1100; v_i_4 = 4'b1000;
    #1;
    push("lanes.o", V_O, 4'b1010);
    push("lanes.o_3", V_O3, 4'b1000);
    push("lanes.o_4", V_O4, 4'b1000);
    drain();
    @(posedge clk);
    #1;
    push("lanes.o_q", V_OQ, 4'b1010);
    push("lanes.o_3_q", V_O3Q, 4'b1000);
    push("lanes.o_4_q", V_O4Q, 4'b1000);
    drain();

    // Random lane patterns, expectation built lane by lane
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      v_i_1 = ra; v_i_2 = rb; v_i_3 = rc; v_i_4 = rd;
      for (int b = 0; b < 4; b++) begin
        e2[b] = (ra[b] == 1'b1 && rb[b] == 1'b1) ? 1'b1 : 1'b0;
        e3[b] = (e2[b] == 1'b1 && rc[b] == 1'b1) ? 1'b1 : 1'b0;
        e4[b] = (e3[b] == 1'b1 && rd[b] == 1'b1) ? 1'b1 : 1'b0;
      end
      #1;
      push($sformatf("rand%0d.o", k), V_O, e2);
      push($sformatf("rand%0d.o_3", k), V_O3, e3);
      push($sformatf("rand%0d.o_4", k), V_O4, e4);
      drain();
      @(posedge clk);
      #1;
      push($sformatf("rand%0d.o_q", k), V_OQ, e2);
      push($sformatf("rand%0d.o_3_q", k), V_O3Q, e3);
      push($sformatf("rand%0d.o_4_q", k), V_O4Q, e4);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
